// File: rtl/pulse_series_decoder.sv
// Pulse burst decoder: counts qualified high pulses per burst and reports the count once the line idles.
// Optional build macro PULSE_SERIES_SYNC_EN inserts a 2-flop input synchronizer (+2 cycles latency).
module pulse_series_decoder #(
    parameter int COUNT_WIDTH = 4,
    parameter int IDLE_CYCLES = 8,
    parameter int MIN_WIDTH   = 2
) (
    input  logic                   i_Clk,
    input  logic                   i_Rst,
    input  logic                   i_Data,
    output logic [COUNT_WIDTH-1:0] o_Count,
    output logic                   o_Valid,
    output logic                   o_Overflow,
    output logic                   o_Busy
);

    localparam int WW = $clog2(MIN_WIDTH + 1);
    // The gap counter never has to hold IDLE_CYCLES itself: the low that would
    // reach it triggers the report instead.
    localparam int GW = $clog2(IDLE_CYCLES);

    localparam logic [WW-1:0]          WIDTH_MIN = WW'(MIN_WIDTH);
    localparam logic [GW-1:0]          GAP_LAST  = GW'(IDLE_CYCLES - 1);
    localparam logic [COUNT_WIDTH-1:0] COUNT_MAX = '1;

    typedef enum logic [1:0] {
        IDLE,
        HIGH,
        GAP
    } state_t;

    state_t                 state;
    logic [WW-1:0]          width;
    logic [GW-1:0]          gap;
    logic [COUNT_WIDTH-1:0] pulse_cnt;
    logic                   ovf;
    logic                   d;

`ifdef PULSE_SERIES_SYNC_EN
    logic [1:0] sync_q;

    always_ff @(posedge i_Clk) begin
        if (i_Rst) sync_q <= '0;
        else       sync_q <= {sync_q[0], i_Data};
    end

    assign d = sync_q[1];
`else
    assign d = i_Data;
`endif

    always_ff @(posedge i_Clk) begin
        if (i_Rst) begin
            state      <= IDLE;
            width      <= '0;
            gap        <= '0;
            pulse_cnt  <= '0;
            ovf        <= 1'b0;
            o_Count    <= '0;
            o_Valid    <= 1'b0;
            o_Overflow <= 1'b0;
            o_Busy     <= 1'b0;
        end else begin
            o_Valid <= 1'b0;
            case (state)
                IDLE: begin
                    if (d) begin
                        state     <= HIGH;
                        width     <= WW'(1);
                        pulse_cnt <= '0;
                        ovf       <= 1'b0;
                        o_Busy    <= 1'b1;
                    end
                end
                HIGH: begin
                    if (d) begin
                        if (width != WIDTH_MIN) width <= width + 1'b1;
                    end else if (width >= WIDTH_MIN) begin
                        if (pulse_cnt == COUNT_MAX) ovf <= 1'b1;
                        else                        pulse_cnt <= pulse_cnt + 1'b1;
                        state <= GAP;
                        gap   <= GW'(1);
                    end else if (pulse_cnt == '0) begin
                        // Glitch with nothing counted yet: the burst never started.
                        state  <= IDLE;
                        o_Busy <= 1'b0;
                    end else begin
                        state <= GAP;
                        gap   <= GW'(1);
                    end
                end
                GAP: begin
                    if (d) begin
                        state <= HIGH;
                        width <= WW'(1);
                    end else if (gap == GAP_LAST) begin
                        state      <= IDLE;
                        o_Valid    <= 1'b1;
                        o_Count    <= pulse_cnt;
                        o_Overflow <= ovf;
                        o_Busy     <= 1'b0;
                    end else begin
                        gap <= gap + 1'b1;
                    end
                end
                default: begin
                    state  <= IDLE;
                    o_Busy <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_pulse_series_decoder.sv
// Randomized scoreboard bench for pulse_series_decoder: a run-length reference model
// predicts every report (cycle, count, overflow) and a monitor checks them on o_Valid.
module tb_pulse_series_decoder;

    localparam int CW   = 4;
    localparam int IDLE = 8;
    localparam int MINW = 2;
    localparam int MAXC = (1 << CW) - 1;
`ifdef PULSE_SERIES_SYNC_EN
    localparam int LAT = 2;
`else
    localparam int LAT = 0;
`endif

    typedef struct {
        int edge_c;
        int cnt;
        int ovf;
    } exp_t;

    logic          clk = 1'b0;
    logic          i_Rst = 1'b1;
    logic          i_Data = 1'b0;
    logic [CW-1:0] o_Count;
    logic          o_Valid;
    logic          o_Overflow;
    logic          o_Busy;

    int   cyc = 0;
    int   checks = 0;
    int   errors = 0;
    int   last_cnt = 0;
    int   last_ovf = 0;
    exp_t exp_q[$];
    bit   seg[$];

    pulse_series_decoder #(
        .COUNT_WIDTH(CW),
        .IDLE_CYCLES(IDLE),
        .MIN_WIDTH  (MINW)
    ) dut (
        .i_Clk     (clk),
        .i_Rst     (i_Rst),
        .i_Data    (i_Data),
        .o_Count   (o_Count),
        .o_Valid   (o_Valid),
        .o_Overflow(o_Overflow),
        .o_Busy    (o_Busy)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input int act, input int exp_v);
        checks++;
        if (act != exp_v) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp_v, cyc);
        end
    endtask

    // Reference: split the sample stream into runs. A high run of >= MINW samples
    // that is followed by a low counts one pulse; a low run of >= IDLE samples while
    // at least one pulse is held closes the burst on its IDLE-th low.
    function automatic void model(input int base);
        int i = 0;
        int n = seg.size();
        int cnt = 0;
        int ovf = 0;
        while (i < n) begin
            int j = i;
            while (j < n && seg[j] == seg[i]) j++;
            if (seg[i]) begin
                if ((j - i) >= MINW && j < n) begin
                    if (cnt == MAXC) ovf = 1;
                    else             cnt++;
                end
            end else if (cnt > 0 && (j - i) >= IDLE) begin
                exp_q.push_back('{base + i + IDLE - 1 + LAT, cnt, ovf});
                last_cnt = cnt;
                last_ovf = ovf;
                cnt = 0;
                ovf = 0;
            end
            i = j;
        end
    endfunction

    task automatic push_run(input bit v, input int len);
        for (int i = 0; i < len; i++) seg.push_back(v);
    endtask

    task automatic drive_seg();
        foreach (seg[i]) begin
            i_Data = seg[i];
            @(negedge clk);
        end
        i_Data = 1'b0;
    endtask

    // Segment always ends with enough lows that any report lands inside it.
    task automatic run_seg(input string name);
        @(negedge clk);
        push_run(1'b0, IDLE + 3);
        model(cyc + 1);
        drive_seg();
        check({name, " busy_idle"}, o_Busy, 0);
        check({name, " count_held"}, o_Count, last_cnt);
        check({name, " ovf_held"}, o_Overflow, last_ovf);
        seg.delete();
    endtask

    task automatic do_reset(input string name);
        @(negedge clk);
        i_Rst  = 1'b1;
        i_Data = 1'b1;
        @(negedge clk);
        check({name, " rst1_outs"}, {o_Valid, o_Busy, o_Overflow, o_Count}, 0);
        i_Data = 1'b0;
        @(negedge clk);
        check({name, " rst2_outs"}, {o_Valid, o_Busy, o_Overflow, o_Count}, 0);
        i_Rst  = 1'b0;
        @(negedge clk);
        check({name, " post_rst_outs"}, {o_Valid, o_Busy, o_Overflow, o_Count}, 0);
        last_cnt = 0;
        last_ovf = 0;
    endtask

    // Monitor: every strobe must match the oldest outstanding prediction.
    always @(negedge clk) begin
        if (!i_Rst && o_Valid) begin
            if (exp_q.size() == 0) begin
                check("unexpected_valid", 1, 0);
            end else begin
                exp_t e;
                e = exp_q.pop_front();
                check("report_cycle", cyc, e.edge_c);
                check("report_count", o_Count, e.cnt);
                check("report_ovf", o_Overflow, e.ovf);
                check("busy_at_report", o_Busy, 0);
            end
        end
    end

    initial begin
        do_reset("t1");

        // Three 2-high/3-low pulses then a long idle.
        for (int p = 0; p < 3; p++) begin
            push_run(1'b1, 2);
            push_run(1'b0, 3);
        end
        run_seg("t2");

        // Lone glitch: no report, previous count held.
        push_run(1'b1, 1);
        push_run(1'b0, 20);
        run_seg("t3");

        // Saturation, then a single-pulse burst clears overflow.
        for (int p = 0; p < 17; p++) begin
            push_run(1'b1, 2);
            push_run(1'b0, 2);
        end
        run_seg("t4a");
        check("t4a sat_count", o_Count, MAXC);
        check("t4a sat_ovf", o_Overflow, 1);
        push_run(1'b1, 2);
        run_seg("t4b");

        // Gap boundary: IDLE-1 lows merge, IDLE lows split.
        push_run(1'b1, 2);
        push_run(1'b0, IDLE - 1);
        push_run(1'b1, 2);
        run_seg("t5a");
        check("t5a merged_count", o_Count, 2);
        push_run(1'b1, 2);
        push_run(1'b0, IDLE);
        push_run(1'b1, 2);
        run_seg("t5b");
        check("t5b split_count", o_Count, 1);

        // Reset mid-burst discards it.
        @(negedge clk);
        push_run(1'b1, 2);
        push_run(1'b0, 1);
        push_run(1'b1, 2);
        push_run(1'b0, 1);
        drive_seg();
        seg.delete();
        do_reset("t6");
        push_run(1'b1, 2);
        run_seg("t6b");

        // Randomized bursts mixing glitches, near-boundary gaps and saturation.
        for (int s = 0; s < 40; s++) begin
            int nr;
            int maxlow;
            nr = $urandom_range(1, 20);
            maxlow = ($urandom_range(0, 1) == 1) ? 3 : IDLE + 1;
            for (int r = 0; r < nr; r++) begin
                push_run(1'b1, $urandom_range(1, 4));
                push_run(1'b0, $urandom_range(1, maxlow));
            end
            run_seg("rand");
        end

        repeat (4) @(negedge clk);
        check("pending_reports", exp_q.size(), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
